// File: rtl/col_readout_pkg.sv
// rtl/col_readout_pkg.sv - shared constants, FSM encoding and hit-word field offsets
package col_readout_pkg;

    localparam int N_SP       = 8;
    localparam int DATA_W     = 26;
    localparam int IDX_W      = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W      = $clog2(TIMEOUT) + 1;

    // Field layout of the per-pixel hit word
    localparam int TOA_MSB  = 25;
    localparam int TOA_LSB  = 17;
    localparam int FTOA_MSB = 16;
    localparam int FTOA_LSB = 12;
    localparam int TOT_MSB  = 11;
    localparam int TOT_LSB  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Round-robin successor of a super-pixel index, wrapping at N_SP-1
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_SP - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// rtl/readout_fifo.sv - synchronous first-word-fall-through FIFO toward the serializer
module readout_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    // Head is shown directly; forced to zero when nothing is stored
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage array; contents are meaningless once count is reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally mod DEPTH; count unchanged on simultaneous push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/column_readout_arbiter.sv
// rtl/column_readout_arbiter.sv - round-robin column readout scheduler with tagged output FIFO
module column_readout_arbiter
    import col_readout_pkg::*;
(
    input  logic                      clk_40MHz,
    input  logic                      rst,
    input  logic                      readout_en,
    input  logic [N_SP-1:0]           sp_req,
    input  logic [N_SP*DATA_W-1:0]    sp_data,
    output logic [N_SP-1:0]           sp_ack,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W+DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]          fifo_count,
    output logic                      busy,
    output logic                      err_stuck
);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_W-1:0]           r_grant;
    logic [IDX_W-1:0]           r_rr_ptr;
    logic [TMO_W-1:0]           r_tmo;
    logic                       r_err;

    logic                       w_found;
    logic [IDX_W-1:0]           w_sel;
    logic [IDX_W-1:0]           w_cand;
    int                         w_j;
    logic                       w_push;
    logic                       w_tmo_hit;
    logic                       w_fifo_empty;
    logic                       w_fifo_full;
    logic [DATA_W-1:0]          w_grant_data;

    // Round-robin search: first requesting pixel at or after rr_ptr
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        w_j     = 0;
        for (int i = 0; i < N_SP; i++) begin
            w_j = int'(r_rr_ptr) + i;
            if (w_j >= N_SP) begin
                w_j = w_j - N_SP;
            end
            w_cand = IDX_W'(w_j);
            if (!w_found && sp_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Next-state logic; a grant needs room in the FIFO so the ACK push never overflows
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (readout_en && w_found && !w_fifo_full) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_push      = 1'b1;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!sp_req[r_grant]) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_40MHz or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant latch, round-robin pointer, release timeout and sticky stuck flag
    always_ff @(posedge clk_40MHz or posedge rst) begin
        if (rst) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_tmo    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_state_nxt == ST_ACK) begin
                r_grant <= w_sel;
            end
            if (r_state == ST_ACK) begin
                r_rr_ptr <= next_idx(r_grant);
            end
            if (r_state == ST_RELEASE) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
            if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    // Data is taken from the granted pixel as presented during ACK
    assign w_grant_data = sp_data[r_grant*DATA_W +: DATA_W];

    assign sp_ack    = (r_state == ST_ACK) ? (N_SP'(1) << r_grant) : '0;
    assign busy      = (r_state != ST_IDLE);
    assign err_stuck = r_err;
    assign out_valid = ~w_fifo_empty;

    readout_fifo #(
        .WIDTH (IDX_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_40MHz),
        .rst   (rst),
        .push  (w_push),
        .pop   (out_valid & out_ready),
        .din   ({r_grant, w_grant_data}),
        .dout  (out_data),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_column_readout_arbiter.sv
// tb/tb_column_readout_arbiter.sv - directed self-checking bench for column_readout_arbiter
module tb_column_readout_arbiter;
    import col_readout_pkg::*;

    logic                      clk_40MHz = 1'b0;
    logic                      rst;
    logic                      readout_en;
    logic [N_SP-1:0]           sp_req;
    logic [N_SP*DATA_W-1:0]    sp_data;
    logic [N_SP-1:0]           sp_ack;
    logic                      out_valid;
    logic                      out_ready;
    logic [IDX_W+DATA_W-1:0]   out_data;
    logic [CNT_W-1:0]          fifo_count;
    logic                      busy;
    logic                      err_stuck;

    logic [DATA_W-1:0]         pd [N_SP];
    logic [IDX_W+DATA_W-1:0]   popq [$];
    int                        n_checks = 0;
    int                        n_fail   = 0;
    int                        g;
    int                        cyc;
    logic                      any_ack;

    always #5 clk_40MHz = ~clk_40MHz;

    for (genvar k = 0; k < N_SP; k++) begin : g_pack
        assign sp_data[k*DATA_W +: DATA_W] = pd[k];
    end

    column_readout_arbiter dut (
        .clk_40MHz  (clk_40MHz),
        .rst        (rst),
        .readout_en (readout_en),
        .sp_req     (sp_req),
        .sp_data    (sp_data),
        .sp_ack     (sp_ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .busy       (busy),
        .err_stuck  (err_stuck)
    );

    always @(negedge clk_40MHz) begin
        if (!rst && out_valid && out_ready) begin
            popq.push_back(out_data);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expd);
        end
    endtask

    function automatic logic [IDX_W+DATA_W-1:0] word_of(input int k);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(k);
        return {idx, pd[k]};
    endfunction

    task automatic tick();
        @(posedge clk_40MHz);
        #1;
    endtask

    task automatic wait_ack(output int idx, output int cycles);
        idx    = -1;
        cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (sp_ack != '0) begin
                for (int k = 0; k < N_SP; k++) begin
                    if (sp_ack[k]) idx = k;
                end
                cycles = c;
                break;
            end
        end
        if (idx < 0) check_eq("ack_timeout", 64'd0, 64'd1);
        else         check_eq("ack_onehot", 64'($onehot(sp_ack)), 64'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_popq(input string tag, input int idxs [6], input int n);
        check_eq({tag, "_n"}, 64'(popq.size()), 64'(n));
        if (popq.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check_eq($sformatf("%s_%0d", tag, i), 64'(popq[i]), 64'(word_of(idxs[i])));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pd[0] = 26'h2A55A5A;
        for (int k = 1; k < N_SP; k++) pd[k] = DATA_W'(32'h0ABC000 + k * 32'h10101);
        rst = 1'b1; readout_en = 1'b0; sp_req = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_ack", 64'(sp_ack), 64'd0);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        check_eq("rst_count", 64'(fifo_count), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_err", 64'(err_stuck), 64'd0);
        rst = 1'b0;
        tick();

        // single request on pixel 0
        readout_en = 1'b1; out_ready = 1'b1; sp_req = 8'b0000_0001;
        wait_ack(g, cyc);
        check_eq("t1_idx", 64'(g), 64'd0);
        check_eq("t1_latency", 64'(cyc), 64'd1);
        check_eq("t1_busy", 64'(busy), 64'd1);
        sp_req = '0;
        tick();
        check_eq("t1_valid", 64'(out_valid), 64'd1);
        check_eq("t1_data", 64'(out_data), 64'h02A55A5A);
        check_eq("t1_count", 64'(fifo_count), 64'd1);
        tick();
        check_eq("t1_drained", 64'(out_valid), 64'd0);
        check_eq("t1_idle", 64'(busy), 64'd0);
        check_eq("t1_err", 64'(err_stuck), 64'd0);

        // all pixels requesting: strict round robin from 0
        apply_reset();
        sp_req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_ack(g, cyc);
            check_eq($sformatf("t2_order%0d", i), 64'(g), 64'(i % N_SP));
            if (g >= 0) sp_req[g] = 1'b0;
            tick();
            tick();
            if (i < 8 && g >= 0) sp_req[g] = 1'b1;
        end
        sp_req = '0;
        repeat (4) tick();

        // back-pressure: rr_ptr=1, pixels 1..6 pending, FIFO fills after 4
        out_ready = 1'b0; sp_req = 8'b0111_1110;
        for (int i = 0; i < 4; i++) begin
            wait_ack(g, cyc);
            check_eq($sformatf("t3_grant%0d", i), 64'(g), 64'(i + 1));
            if (g >= 0) sp_req[g] = 1'b0;
        end
        any_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sp_ack != '0) any_ack = 1'b1;
        end
        check_eq("t3_no_ack_full", 64'(any_ack), 64'd0);
        check_eq("t3_count_full", 64'(fifo_count), 64'd4);
        check_eq("t3_idle_full", 64'(busy), 64'd0);
        popq.delete();
        out_ready = 1'b1;
        wait_ack(g, cyc);
        check_eq("t3_resume5", 64'(g), 64'd5);
        if (g >= 0) sp_req[g] = 1'b0;
        wait_ack(g, cyc);
        check_eq("t3_resume6", 64'(g), 64'd6);
        if (g >= 0) sp_req[g] = 1'b0;
        repeat (6) tick();
        check_popq("t3_drain", '{1, 2, 3, 4, 5, 6}, 6);

        // stuck request on pixel 3, rr_ptr=7
        popq.delete();
        sp_req = 8'b0000_1000;
        wait_ack(g, cyc);
        check_eq("t4_idx3", 64'(g), 64'd3);
        sp_req = 8'b0010_1000;
        repeat (16) tick();
        check_eq("t4_err_before", 64'(err_stuck), 64'd0);
        check_eq("t4_busy_release", 64'(busy), 64'd1);
        tick();
        check_eq("t4_err_set", 64'(err_stuck), 64'd1);
        check_eq("t4_idle_after", 64'(busy), 64'd0);
        wait_ack(g, cyc);
        check_eq("t4_next5", 64'(g), 64'd5);
        check_eq("t4_next_lat", 64'(cyc), 64'd1);
        sp_req = '0;
        repeat (3) tick();
        check_popq("t4_push", '{3, 5, 0, 0, 0, 0}, 2);
        check_eq("t4_err_sticky", 64'(err_stuck), 64'd1);

        // simultaneous push/pop at count 2, rr_ptr=6
        popq.delete();
        out_ready = 1'b0; sp_req = 8'b0000_0011;
        wait_ack(g, cyc);
        check_eq("t5_g0", 64'(g), 64'd0);
        sp_req[0] = 1'b0;
        wait_ack(g, cyc);
        check_eq("t5_g1", 64'(g), 64'd1);
        sp_req = 8'b0000_0100;
        wait_ack(g, cyc);
        check_eq("t5_g2", 64'(g), 64'd2);
        check_eq("t5_count_pre", 64'(fifo_count), 64'd2);
        out_ready = 1'b1; sp_req = '0;
        tick();
        check_eq("t5_count_pp", 64'(fifo_count), 64'd2);
        check_eq("t5_head", 64'(out_data), 64'(word_of(1)));
        repeat (3) tick();
        check_popq("t5_order", '{0, 1, 2, 0, 0, 0}, 3);

        // readout_en dropped during ACK, rr_ptr=3
        popq.delete();
        sp_req = 8'b0001_0000;
        wait_ack(g, cyc);
        check_eq("t5_g4", 64'(g), 64'd4);
        readout_en = 1'b0; sp_req = 8'b0100_0000;
        repeat (3) tick();
        check_popq("t5_en_done", '{4, 0, 0, 0, 0, 0}, 1);
        any_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sp_ack != '0) any_ack = 1'b1;
        end
        check_eq("t5_en_hold", 64'(any_ack), 64'd0);
        check_eq("t5_en_idle", 64'(busy), 64'd0);
        readout_en = 1'b1;
        wait_ack(g, cyc);
        check_eq("t5_g6", 64'(g), 64'd6);
        sp_req = '0;
        repeat (3) tick();

        // async reset during ACK, rr_ptr=7
        out_ready = 1'b0; sp_req = 8'b0000_0010;
        wait_ack(g, cyc);
        check_eq("t6_g1", 64'(g), 64'd1);
        sp_req = 8'b0000_0100;
        wait_ack(g, cyc);
        check_eq("t6_g2", 64'(g), 64'd2);
        check_eq("t6_count_pre", 64'(fifo_count), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_ack_rst", 64'(sp_ack), 64'd0);
        check_eq("t6_count_rst", 64'(fifo_count), 64'd0);
        check_eq("t6_valid_rst", 64'(out_valid), 64'd0);
        check_eq("t6_data_rst", 64'(out_data), 64'd0);
        check_eq("t6_busy_rst", 64'(busy), 64'd0);
        check_eq("t6_err_rst", 64'(err_stuck), 64'd0);
        sp_req = '0;
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1; sp_req = 8'b0010_0001;
        wait_ack(g, cyc);
        check_eq("t6_first0", 64'(g), 64'd0);
        sp_req[0] = 1'b0;
        wait_ack(g, cyc);
        check_eq("t6_then5", 64'(g), 64'd5);
        sp_req = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
